execute_multiply: RTL and testbench

//  Iterative MUL/IMUL unit for the execute stage; the companion of the divide unit.

---
 rtl/execute_multiply.sv | 152 +++++++++++++++
 tb/tb_execute_multiply.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/execute_multiply.sv
// Iterative MUL/IMUL unit for the execute stage: shift-and-add over the
// multiplier magnitude, sign fix-up at the end, product held until retire/flush.
module execute_multiply #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_reset,
    input  logic        exe_ready,
    input  logic [6:0]  exe_cmd,
    input  logic        exe_is_8bit,
    input  logic        exe_operand_16bit,
    input  logic        exe_operand_32bit,
    input  logic [31:0] eax,
    input  logic [31:0] src,
    output logic        mul_busy,
    output logic [63:0] mul_result,
    output logic        mul_overflow
);

    localparam logic [6:0] CMD_MUL  = 7'd38;
    localparam logic [6:0] CMD_IMUL = 7'd39;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    typedef enum logic [1:0] {SZ8, SZ16, SZ32} size_t;

    state_t      state;
    size_t       size_q;
    logic        is_imul;
    logic        neg;
    logic [63:0] a_shift;
    logic [31:0] mult;
    logic [63:0] acc;
    logic [4:0]  cnt;

    // Size 32 is the fall-through case, so the explicit 32-bit flag carries no information.
    logic unused_size32;
    assign unused_size32 = exe_operand_32bit;

    logic        start_cmd;
    logic        imul_in;
    size_t       size_in;
    logic [31:0] mask_in;
    logic        a_sign;
    logic        b_sign;
    logic [31:0] a_raw;
    logic [31:0] b_raw;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [4:0]  steps_in;

    always_comb begin
        start_cmd = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_IMUL);
        imul_in   = (exe_cmd == CMD_IMUL);
        size_in   = exe_is_8bit ? SZ8 : (exe_operand_16bit ? SZ16 : SZ32);
        mask_in   = 32'hFFFF_FFFF;
        a_sign    = eax[31];
        b_sign    = src[31];
        steps_in  = 5'(32 / BITS_PER_CYCLE - 1);
        case (size_in)
            SZ8: begin
                mask_in  = 32'h0000_00FF;
                a_sign   = eax[7];
                b_sign   = src[7];
                steps_in = 5'(8 / BITS_PER_CYCLE - 1);
            end
            SZ16: begin
                mask_in  = 32'h0000_FFFF;
                a_sign   = eax[15];
                b_sign   = src[15];
                steps_in = 5'(16 / BITS_PER_CYCLE - 1);
            end
            default: ;
        endcase
        a_raw = eax & mask_in;
        b_raw = src & mask_in;
        a_abs = (imul_in && a_sign) ? ((~a_raw + 32'd1) & mask_in) : a_raw;
        b_abs = (imul_in && b_sign) ? ((~b_raw + 32'd1) & mask_in) : b_raw;
    end

    // Partial product for the low BITS_PER_CYCLE multiplier bits at the current alignment.
    logic [63:0] partial;
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mult[i]) partial = partial + (a_shift << i);
        end
    end

    // Negating the 64-bit magnitude yields the sign-extended 2N-bit product directly.
    logic [63:0] product;
    logic        ov_calc;
    always_comb begin
        product = neg ? (64'd0 - acc) : acc;
        case (size_q)
            SZ8:  ov_calc = is_imul ? (product[15:8]  != {8{product[7]}})   : (product[15:8]  != '0);
            SZ16: ov_calc = is_imul ? (product[31:16] != {16{product[15]}}) : (product[31:16] != '0);
            default: ov_calc = is_imul ? (product[63:32] != {32{product[31]}}) : (product[63:32] != '0);
        endcase
    end

    assign mul_busy = ((state == IDLE) && start_cmd) || (state == RUN) || (state == FIX);

    always_ff @(posedge clk) begin
        // NOTE: the datapath is cleared along with the state so a flush never leaves a stale product visible.
        if (rst || exe_reset) begin
            state        <= IDLE;
            size_q       <= SZ32;
            is_imul      <= 1'b0;
            neg          <= 1'b0;
            a_shift      <= '0;
            mult         <= '0;
            acc          <= '0;
            cnt          <= '0;
            mul_result   <= '0;
            mul_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        state   <= RUN;
                        size_q  <= size_in;
                        is_imul <= imul_in;
                        neg     <= imul_in && (a_sign ^ b_sign);
                        a_shift <= {32'd0, a_abs};
                        mult    <= b_abs;
                        acc     <= '0;
                        cnt     <= steps_in;
                    end
                end
                RUN: begin
                    acc     <= acc + partial;
                    a_shift <= a_shift << BITS_PER_CYCLE;
                    mult    <= mult >> BITS_PER_CYCLE;
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 5'd1;
                end
                FIX: begin
                    mul_result   <= product;
                    mul_overflow <= ov_calc;
                    state        <= DONE;
                end
                DONE: begin
                    // A command present in the retire cycle is only seen once back in IDLE.
                    if (exe_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_multiply.sv
// Directed bench for execute_multiply: three instances (1, 2 and 4 bits per
// cycle) share the stimulus so results and busy windows are checked for each.
module tb_execute_multiply;

    localparam logic [6:0] CMD_NOP  = 7'd0;
    localparam logic [6:0] CMD_MUL  = 7'd38;
    localparam logic [6:0] CMD_IMUL = 7'd39;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_reset;
    logic        exe_ready;
    logic [6:0]  exe_cmd;
    logic        exe_is_8bit;
    logic        exe_operand_16bit;
    logic        exe_operand_32bit;
    logic [31:0] eax;
    logic [31:0] src;

    logic        busy1, busy2, busy4;
    logic [63:0] res1, res2, res4;
    logic        ov1, ov2, ov4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_multiply #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .exe_reset(exe_reset), .exe_ready(exe_ready),
        .exe_cmd(exe_cmd), .exe_is_8bit(exe_is_8bit),
        .exe_operand_16bit(exe_operand_16bit), .exe_operand_32bit(exe_operand_32bit),
        .eax(eax), .src(src), .mul_busy(busy1), .mul_result(res1), .mul_overflow(ov1)
    );

    execute_multiply #(.BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .exe_reset(exe_reset), .exe_ready(exe_ready),
        .exe_cmd(exe_cmd), .exe_is_8bit(exe_is_8bit),
        .exe_operand_16bit(exe_operand_16bit), .exe_operand_32bit(exe_operand_32bit),
        .eax(eax), .src(src), .mul_busy(busy2), .mul_result(res2), .mul_overflow(ov2)
    );

    execute_multiply #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .exe_reset(exe_reset), .exe_ready(exe_ready),
        .exe_cmd(exe_cmd), .exe_is_8bit(exe_is_8bit),
        .exe_operand_16bit(exe_operand_16bit), .exe_operand_32bit(exe_operand_32bit),
        .eax(eax), .src(src), .mul_busy(busy4), .mul_result(res4), .mul_overflow(ov4)
    );

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // flags = {is_8bit, operand_16bit, operand_32bit}; n is the effective size.
    task automatic run_op(input string tag, input logic [6:0] cmd, input logic [2:0] flags,
                          input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input logic exp_ov);
        int c1 = 0;
        int c2 = 0;
        int c4 = 0;
        bit d1 = 1'b0;
        bit d2 = 1'b0;
        bit d4 = 1'b0;
        @(negedge clk);
        exe_ready = 1'b0;
        exe_cmd   = cmd;
        {exe_is_8bit, exe_operand_16bit, exe_operand_32bit} = flags;
        eax = a;
        src = b;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (!d1) begin if (busy1) c1++; else d1 = 1'b1; end
            if (!d2) begin if (busy2) c2++; else d2 = 1'b1; end
            if (!d4) begin if (busy4) c4++; else d4 = 1'b1; end
            if (d1 && d2 && d4) break;
            @(negedge clk);
            // Inputs change mid-operation; the unit must ignore them.
            exe_cmd = CMD_NOP;
            eax     = ~a;
            src     = ~b;
        end
        check({tag, " busy B1"}, 64'(c1), 64'(2 + n));
        check({tag, " busy B2"}, 64'(c2), 64'(2 + n / 2));
        check({tag, " busy B4"}, 64'(c4), 64'(2 + n / 4));
        check({tag, " result B1"}, res1, exp_res);
        check({tag, " result B2"}, res2, exp_res);
        check({tag, " result B4"}, res4, exp_res);
        check({tag, " ovf B1"}, 64'(ov1), 64'(exp_ov));
        check({tag, " ovf B2"}, 64'(ov2), 64'(exp_ov));
        check({tag, " ovf B4"}, 64'(ov4), 64'(exp_ov));
    endtask

    task automatic retire();
        @(negedge clk);
        exe_ready = 1'b1;
        @(negedge clk);
        exe_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exe_reset = 1'b0;
        exe_ready = 1'b0;
        exe_cmd = CMD_NOP;
        {exe_is_8bit, exe_operand_16bit, exe_operand_32bit} = 3'b001;
        eax = 32'h1234_5678;
        src = 32'h9ABC_DEF0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset busy", 64'(busy1), 64'd0);
        check("reset result", res1, 64'd0);
        check("reset ovf", 64'(ov1), 64'd0);

        run_op("mul8 ff*ff", CMD_MUL, 3'b100, 8, 32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_FE01, 1'b1);
        retire();
        run_op("imul16 -1*2", CMD_IMUL, 3'b010, 16, 32'h0000_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        retire();
        run_op("imul32 min*-1", CMD_IMUL, 3'b001, 32, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        retire();
        run_op("mul32 max*max", CMD_MUL, 3'b001, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        retire();
        // 8-bit flag wins over 16-bit; upper operand bits are ignored: 0xFF*0x02.
        run_op("size prio", CMD_MUL, 3'b110, 8, 32'hABCD_E1FF, 32'h5555_0102, 64'h0000_0000_0000_01FE, 1'b1);
        retire();
        run_op("imul8 -1*1", CMD_IMUL, 3'b100, 8, 32'h0000_00FF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        retire();
        run_op("mul8 small", CMD_MUL, 3'b100, 8, 32'h0000_0010, 32'h0000_000F, 64'h0000_0000_0000_00F0, 1'b0);
        retire();
        run_op("imul32 7*-3", CMD_IMUL, 3'b001, 32, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        retire();

        // Flush in the 5th RUN cycle; a simultaneous exe_ready must not matter.
        @(negedge clk);
        exe_cmd = CMD_MUL;
        {exe_is_8bit, exe_operand_16bit, exe_operand_32bit} = 3'b001;
        eax = 32'hFFFF_FFFF;
        src = 32'hFFFF_FFFF;
        repeat (5) begin
            @(negedge clk);
            exe_cmd = CMD_NOP;
        end
        exe_reset = 1'b1;
        exe_ready = 1'b1;
        @(negedge clk);
        exe_reset = 1'b0;
        exe_ready = 1'b0;
        #1;
        check("flush busy B1", 64'(busy1), 64'd0);
        check("flush result B1", res1, 64'd0);
        check("flush ovf B1", 64'(ov1), 64'd0);
        check("flush busy B4", 64'(busy4), 64'd0);
        check("flush result B4", res4, 64'd0);

        // Flush together with a start in IDLE: no operation may begin.
        @(negedge clk);
        exe_cmd   = CMD_MUL;
        exe_reset = 1'b1;
        @(negedge clk);
        exe_cmd   = CMD_NOP;
        exe_reset = 1'b0;
        #1;
        check("flush beats start", 64'(busy1), 64'd0);

        // DX = 0x0001 for this product, so CF/OF is set.
        run_op("mul16 after flush", CMD_MUL, 3'b010, 16, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, 1'b1);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("hold busy", 64'(busy1), 64'd0);
            check("hold result", res1, 64'h0000_0000_0001_2340);
        end

        // Retire with a new IMUL already on exe_cmd; it must start one cycle later.
        @(negedge clk);
        exe_ready = 1'b1;
        exe_cmd   = CMD_IMUL;
        {exe_is_8bit, exe_operand_16bit, exe_operand_32bit} = 3'b100;
        eax = 32'h0000_0080;
        src = 32'h0000_0080;
        #1;
        check("retire cycle busy", 64'(busy1), 64'd0);
        run_op("imul8 b2b", CMD_IMUL, 3'b100, 8, 32'h0000_0080, 32'h0000_0080, 64'h0000_0000_0000_4000, 1'b1);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
